cpu_mem_bridge: RTL and testbench
=================================

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, giving the memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack (range 1..255).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 instr_read  in  1  CPU instruction-fetch request (level).
REQ-006 instr_addr  in  32  fetch byte address.
REQ-007 data_read  in  1  CPU load request (level).
REQ-008 data_write  in  4  CPU byte-write enables; nonzero means store request.
REQ-009 data_addr  in  32  load/store byte address.
REQ-010 data_in  in  32  store data.
REQ-011 instr_out  out  32  fetched instruction, registered.
REQ-012 data_out  out  32  loaded word, registered.
REQ-013 cpu_stall  out  1  high while an accepted CPU request is incomplete.
REQ-014 bus_err  out  1  one-cycle pulse on timeout or misaligned abort.
REQ-015 mem_req  out  1  memory request, held until acknowledged.
REQ-016 mem_we  out  4  memory byte-write enables (0 = read).
REQ-017 mem_addr  out  MEM_AW  word address = byte address [MEM_AW+1:2].
REQ-018 mem_wdata  out  32  write data.
REQ-019 mem_rdata  in  32  read data, valid in the mem_ack cycle.
REQ-020 mem_ack  in  1  transfer completes on an edge where mem_req and mem_ack are both high.

Function
REQ-021 SHALL implement FSM states IDLE, DATA, FETCH and DONE.
REQ-022 IDLE: data request (data_read or data_write != 0) -> DATA; else instr_read -> FETCH; else stay in IDLE.
REQ-023 On leaving IDLE with both data and fetch requests, SHALL latch pend_fetch = 1.
REQ-024 All request fields (address, enables, write data) SHALL be latched on leaving IDLE; mem_* outputs SHALL remain stable until ack or abort.
REQ-025 DATA completion: a read latches mem_rdata into data_out; a write leaves data_out unchanged. Next state is FETCH if pend_fetch, else DONE.
REQ-026 FETCH completion SHALL latch mem_rdata into instr_out, clear pend_fetch, and go to DONE.
REQ-027 DONE SHALL last exactly one cycle with cpu_stall = 0 and mem_req = 0, then go to IDLE. No request is sampled in DONE.
REQ-028 cpu_stall SHALL be 1 in DATA and FETCH, and combinationally 1 in IDLE whenever any request input is active; otherwise 0.
REQ-029 mem_req SHALL be 1 only in DATA and FETCH. mem_we = latched data_write in DATA and 0 in FETCH.
REQ-030 Minimum latency, request to DONE: 2 cycles with mem_ack high in the first request cycle. Data plus fetch with immediate acks: 3 cycles.
REQ-031 Wait counter SHALL clear on entering DATA or FETCH and increment each unacknowledged cycle. On reaching TIMEOUT it SHALL pulse bus_err, drop mem_req, clear pend_fetch, and go to DONE with outputs unchanged.
REQ-032 mem_ack while mem_req = 0 SHALL be ignored.

Reset
REQ-033 On rst: state = IDLE, instr_out = 32'h0000_0013 (NOP), data_out = 0, mem_req = 0, mem_we = 0, cpu_stall = 0, bus_err = 0, pend_fetch = 0, wait counter = 0.
REQ-034 rst mid-transfer SHALL abort at the same edge; an ack arriving after reset SHALL be ignored.

Configuration
REQ-035 With MISALIGN_CHK_EN defined: a store with data_write == 4'b1111 and data_addr[1:0] != 0 SHALL NOT issue mem_req. It SHALL pulse bus_err in the cycle after acceptance and proceed as if acknowledged, with no memory write.
REQ-036 Without MISALIGN_CHK_EN: no alignment check; the address is truncated to a word and the access is issued.

Structure
REQ-037 Package cpu_mem_pkg SHALL hold the FSM state typedef and the NOP constant 32'h0000_0013.
REQ-038 The wait counter SHALL be sub-module bus_timer (inputs clear and tick; output expired).

Verification
REQ-039 Reset: assert rst 2 cycles -> instr_out = 0x00000013, mem_req = 0, cpu_stall = 0.
REQ-040 Fetch: instr_read = 1, instr_addr = 0x40, ack with rdata 0x00500093 after 3 cycles -> mem_addr = 0x10, instr_out = 0x00500093, one DONE cycle with cpu_stall = 0.
REQ-041 Both requests: store 0xDEADBEEF at data_addr 0x100 with data_write = 1111 plus fetch at 0x44, immediate acks -> DATA (mem_we = 1111, mem_addr = 0x40), then FETCH (mem_we = 0, mem_addr = 0x11), then DONE.
REQ-042 Timeout: data_read, mem_ack tied 0, TIMEOUT = 4 -> bus_err pulses once after 4 wait cycles, mem_req drops, data_out unchanged.
REQ-043 Misaligned: MISALIGN_CHK_EN defined, data_write = 1111, data_addr = 0x102 -> mem_req never high, bus_err pulses. Undefined -> write issued to mem_addr = 0x40.
REQ-044 Reset mid-transfer: rst during FETCH, then mem_ack high -> instr_out stays NOP, state IDLE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-to-memory bridge: FSM state encoding and the reset instruction.
// Latency: none (declarations only). Backpressure: not applicable.
// Also holds a small helper that decodes whether the CPU is asking for a data access.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          TIMER_W   = 8;

    function automatic logic is_data_req(input logic rd, input logic [3:0] we);
        return rd || (we != 4'b0000);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Wait-cycle counter for an outstanding memory request; expired flags the last allowed cycle.
// Latency: expired is combinational from the current count and tick.
// Backpressure: none; clear has priority over tick.
module bus_timer
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th consecutive unacknowledged cycle.
    assign expired = tick && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Arbitrates CPU fetch/load/store onto one memory port, data first then a pending fetch.
// Latency: 2 cycles request->DONE with immediate ack, 3 for data+fetch; DONE lasts one cycle.
// Backpressure: cpu_stall holds the CPU; mem_req held until mem_ack or TIMEOUT abort. Optional MISALIGN_CHK_EN.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int MEM_AW  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [31:0]       instr_addr,
    input  logic              data_read,
    input  logic [3:0]        data_write,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       instr_out,
    output logic [31:0]       data_out,
    output logic              cpu_stall,
    output logic              bus_err,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    state_t state, state_nxt;

    logic              pend_fetch;
    logic              misalign_q;
    logic [3:0]        data_we_q;
    logic [MEM_AW-1:0] data_addr_q;
    logic [MEM_AW-1:0] fetch_addr_q;
    logic [31:0]       wdata_q;

    logic data_req;
    logic any_req;
    logic misalign_now;
    logic accept;
    logic timer_clr;
    logic timer_exp;
    logic data_done;
    logic fetch_done;
    logic unused_addr_bits;

    assign data_req = is_data_req(data_read, data_write);
    assign any_req  = data_req || instr_read;
    assign accept   = (state == IDLE) && any_req;

`ifdef MISALIGN_CHK_EN
    assign misalign_now = data_req && (data_write == 4'b1111) && (data_addr[1:0] != 2'b00);
`else
    assign misalign_now = 1'b0;
`endif

    assign unused_addr_bits = ^{instr_addr[31:MEM_AW+2], instr_addr[1:0],
                                data_addr[31:MEM_AW+2], data_addr[1:0]};

    // A misaligned full-word store never reaches the memory port.
    assign mem_req   = ((state == DATA) && !misalign_q) || (state == FETCH);
    assign mem_wdata = wdata_q;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .tick    (mem_req && !mem_ack),
        .expired (timer_exp)
    );

    always_comb begin
        state_nxt  = state;
        timer_clr  = 1'b0;
        data_done  = 1'b0;
        fetch_done = 1'b0;
        cpu_stall  = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = data_addr_q;
        case (state)
            IDLE: begin
                cpu_stall = any_req;
                if (data_req) begin
                    state_nxt = DATA;
                    timer_clr = 1'b1;
                end else if (instr_read) begin
                    state_nxt = FETCH;
                    timer_clr = 1'b1;
                end
            end
            DATA: begin
                cpu_stall = 1'b1;
                mem_we    = misalign_q ? 4'b0000 : data_we_q;
                mem_addr  = data_addr_q;
                if (misalign_q || mem_ack) begin
                    data_done = mem_ack && !misalign_q;
                    state_nxt = pend_fetch ? FETCH : DONE;
                    timer_clr = pend_fetch;
                end else if (timer_exp) begin
                    state_nxt = DONE;
                end
            end
            FETCH: begin
                cpu_stall = 1'b1;
                mem_addr  = fetch_addr_q;
                if (mem_ack) begin
                    fetch_done = 1'b1;
                    state_nxt  = DONE;
                end else if (timer_exp) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            instr_out    <= NOP_INSTR;
            data_out     <= 32'h0;
            bus_err      <= 1'b0;
            pend_fetch   <= 1'b0;
            misalign_q   <= 1'b0;
            data_we_q    <= 4'b0000;
            data_addr_q  <= '0;
            fetch_addr_q <= '0;
            wdata_q      <= 32'h0;
        end else begin
            state   <= state_nxt;
            bus_err <= 1'b0;
            if (accept) begin
                data_addr_q  <= data_addr[MEM_AW+1:2];
                fetch_addr_q <= instr_addr[MEM_AW+1:2];
                data_we_q    <= data_write;
                wdata_q      <= data_in;
                pend_fetch   <= data_req && instr_read;
                misalign_q   <= misalign_now;
                bus_err      <= misalign_now;
            end
            if (data_done && (data_we_q == 4'b0000)) begin
                data_out <= mem_rdata;
            end
            if (fetch_done) begin
                instr_out  <= mem_rdata;
                pend_fetch <= 1'b0;
            end
            // Timeout leaves data_out/instr_out untouched and drops any queued fetch.
            if (timer_exp && (state_nxt == DONE)) begin
                bus_err    <= 1'b1;
                pend_fetch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: expected memory accesses are queued when a request is
// driven and checked when mem_req appears; outputs are sampled 2 ns after the rising edge.
module tb_cpu_mem_bridge;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] instr_out;
    logic [31:0] data_out;
    logic        cpu_stall;
    logic        bus_err;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int   n_assert = 0;
    int   n_fail   = 0;
    acc_t sb[$];

    always #5 clk = ~clk;

    cpu_mem_bridge #(
        .MEM_AW  (16),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_read (instr_read),
        .instr_addr (instr_addr),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .instr_out  (instr_out),
        .data_out   (data_out),
        .cpu_stall  (cpu_stall),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drop_reqs();
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 4'b0000;
    endtask

    // Entered 2 ns into a cycle where a transfer should be on the bus; returns in the next state.
    task automatic serve(input string tag, input int wait_cyc, input logic [31:0] rd);
        acc_t e;
        e = '{addr: 16'h0, we: 4'h0, wdata: 32'h0};
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
            chk({tag, "_we"}, 32'(mem_we), 32'(e.we));
            if (e.we != 4'b0000) chk({tag, "_wdata"}, mem_wdata, e.wdata);
        end
        repeat (wait_cyc) begin
            next_cycle();
            chk({tag, "_hold"}, 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, e.we, e.addr}));
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        #1;
    endtask

    initial begin
        acc_t e;
        rst        = 1'b1;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        instr_addr = 32'h0;
        data_addr  = 32'h0;
        data_in    = 32'h0;
        drop_reqs();

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_instr_out", instr_out, 32'h0000_0013);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // Fetch at 0x40, ack on the third FETCH cycle
        instr_read = 1'b1;
        instr_addr = 32'h40;
        sb.push_back('{addr: 16'h10, we: 4'h0, wdata: 32'h0});
        #1;
        chk("fetch_idle_stall", 32'(cpu_stall), 32'd1);
        chk("fetch_idle_noreq", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 drop_reqs();
        #1;
        serve("fetch", 2, 32'h0050_0093);
        chk("fetch_done_stall", 32'(cpu_stall), 32'd0);
        chk("fetch_done_req", 32'(mem_req), 32'd0);
        chk("fetch_instr_out", instr_out, 32'h0050_0093);
        next_cycle();
        chk("fetch_idle_after", 32'(cpu_stall), 32'd0);

        // Ack with no request outstanding must be ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        #1;
        chk("stray_ack_data_out", data_out, 32'h0);
        chk("stray_ack_instr_out", instr_out, 32'h0050_0093);
        chk("stray_ack_req", 32'(mem_req), 32'd0);

        // Store plus fetch, immediate acks: DATA, FETCH, DONE
        data_write = 4'b1111;
        data_addr  = 32'h100;
        data_in    = 32'hDEAD_BEEF;
        instr_read = 1'b1;
        instr_addr = 32'h44;
        sb.push_back('{addr: 16'h40, we: 4'hF, wdata: 32'hDEAD_BEEF});
        sb.push_back('{addr: 16'h11, we: 4'h0, wdata: 32'h0});
        @(posedge clk);
        #1 drop_reqs();
        #1;
        serve("both_data", 0, 32'hAAAA_5555);
        serve("both_fetch", 0, 32'h0000_0033);
        chk("both_done_stall", 32'(cpu_stall), 32'd0);
        chk("both_done_req", 32'(mem_req), 32'd0);
        chk("both_instr_out", instr_out, 32'h0000_0033);
        chk("both_data_out_kept", data_out, 32'h0);
        next_cycle();

        // Load at 0x208, one wait cycle
        data_read = 1'b1;
        data_addr = 32'h208;
        sb.push_back('{addr: 16'h82, we: 4'h0, wdata: 32'h0});
        @(posedge clk);
        #1 drop_reqs();
        #1;
        serve("load", 1, 32'hCAFE_F00D);
        chk("load_data_out", data_out, 32'hCAFE_F00D);
        chk("load_done_stall", 32'(cpu_stall), 32'd0);
        next_cycle();

        // Timeout: no ack for TIMEOUT=4 cycles
        data_read = 1'b1;
        data_addr = 32'h300;
        sb.push_back('{addr: 16'hC0, we: 4'h0, wdata: 32'h0});
        @(posedge clk);
        #1 drop_reqs();
        #1;
        chk("to_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("to_addr", 32'(mem_addr), 32'(e.addr));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_wait%0d_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("to_wait%0d_err", i), 32'(bus_err), 32'd0);
            next_cycle();
        end
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req_dropped", 32'(mem_req), 32'd0);
        chk("to_stall", 32'(cpu_stall), 32'd0);
        chk("to_data_out_kept", data_out, 32'hCAFE_F00D);
        next_cycle();
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

        // Misaligned full-word store
        data_write = 4'b1111;
        data_addr  = 32'h102;
        data_in    = 32'h1122_3344;
`ifdef MISALIGN_CHK_EN
        @(posedge clk);
        #1 drop_reqs();
        #1;
        chk("mis_no_req", 32'(mem_req), 32'd0);
        chk("mis_bus_err", 32'(bus_err), 32'd1);
        chk("mis_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        chk("mis_done_req", 32'(mem_req), 32'd0);
        chk("mis_done_err", 32'(bus_err), 32'd0);
        chk("mis_done_stall", 32'(cpu_stall), 32'd0);
`else
        sb.push_back('{addr: 16'h40, we: 4'hF, wdata: 32'h1122_3344});
        @(posedge clk);
        #1 drop_reqs();
        #1;
        chk("mis_no_err", 32'(bus_err), 32'd0);
        serve("mis_write", 0, 32'h0);
        chk("mis_done_stall", 32'(cpu_stall), 32'd0);
        chk("mis_done_err", 32'(bus_err), 32'd0);
`endif
        next_cycle();

        // Reset during FETCH, then a late ack
        instr_read = 1'b1;
        instr_addr = 32'h80;
        @(posedge clk);
        #1 drop_reqs();
        #1;
        chk("rmid_req", 32'(mem_req), 32'd1);
        chk("rmid_addr", 32'(mem_addr), 32'h20);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rmid_req_off", 32'(mem_req), 32'd0);
        chk("rmid_stall_off", 32'(cpu_stall), 32'd0);
        chk("rmid_instr_nop", instr_out, 32'h0000_0013);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        #1;
        chk("rmid_late_ack_nop", instr_out, 32'h0000_0013);
        chk("rmid_late_ack_req", 32'(mem_req), 32'd0);
        chk("rmid_idle_stall", 32'(cpu_stall), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
